// File: rtl/fmadd_seq_ctrl.sv
// Sequencing controller for the single-precision FMADD datapath: request handshake, stage enables, response.
// Optional watchdog on the multiplier wait compiled in with FMADD_SEQ_CTRL_WDOG_EN.
module fmadd_seq_ctrl #(
  parameter int STD      = 31,
  parameter int OPW      = 2,
  parameter int WDOG_CYC = 15
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [2:0]     req_rm,
  input  logic [STD:0]   req_a,
  input  logic [STD:0]   req_b,
  input  logic [STD:0]   req_c,
  input  logic           flush,
  output logic [STD:0]   op_a,
  output logic [STD:0]   op_b,
  output logic [STD:0]   op_c,
  output logic [2:0]     op_rm,
  output logic           op_neg_prod,
  output logic           op_neg_add,
  output logic           mul_start,
  input  logic           mul_done,
  output logic           pn_en,
  output logic           add_en,
  output logic           rnd_en,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_err,
  output logic           busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PN    = 3'd3;
  localparam logic [2:0] S_ADD   = 3'd4;
  localparam logic [2:0] S_RND   = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic       accept_s;
  logic       timeout_s;
  logic       wdog_hit_s;

  function automatic logic neg_prod_f(input logic [OPW-1:0] op);
    return op[1];
  endfunction

  function automatic logic neg_add_f(input logic [OPW-1:0] op);
    return op[0] ^ op[1];
  endfunction

  // Next-state decode; flush overrides every transition, including the response handshake.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = S_START;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_START: state_nxt_s = S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            state_nxt_s = S_PN;
          end else if (wdog_hit_s) begin
            timeout_s   = 1'b1;
            state_nxt_s = S_RESP;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_PN:  state_nxt_s = S_ADD;
        S_ADD: state_nxt_s = S_RND;
        S_RND: state_nxt_s = S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_RESP;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, registered stage strobes/handshake outputs, and operand latch on accept.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r     <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      pn_en       <= 1'b0;
      add_en      <= 1'b0;
      rnd_en      <= 1'b0;
      rsp_valid   <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      op_rm       <= 3'd0;
      op_neg_prod <= 1'b0;
      op_neg_add  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      req_ready <= (state_nxt_s == S_IDLE);
      busy      <= (state_nxt_s != S_IDLE);
      mul_start <= (state_nxt_s == S_START);
      pn_en     <= (state_nxt_s == S_PN);
      add_en    <= (state_nxt_s == S_ADD);
      rnd_en    <= (state_nxt_s == S_RND);
      rsp_valid <= (state_nxt_s == S_RESP);
      if (accept_s) begin
        op_a        <= req_a;
        op_b        <= req_b;
        op_c        <= req_c;
        op_rm       <= req_rm;
        op_neg_prod <= neg_prod_f(req_op);
        op_neg_add  <= neg_add_f(req_op);
      end else begin
        op_a        <= op_a;
        op_b        <= op_b;
        op_c        <= op_c;
        op_rm       <= op_rm;
        op_neg_prod <= op_neg_prod;
        op_neg_add  <= op_neg_add;
      end
    end
  end

`ifdef FMADD_SEQ_CTRL_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYC + 1);

  logic [CNT_W-1:0] wdog_cnt_r;
  logic [CNT_W-1:0] wdog_inc_s;

  assign wdog_inc_s = wdog_cnt_r + CNT_W'(1);
  // Fires on the WAIT cycle whose increment would bring the count up to the limit.
  assign wdog_hit_s = (state_r == S_WAIT) && (wdog_inc_s == CNT_W'(WDOG_CYC));

  // Counts WAIT cycles without mul_done; held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wdog_cnt_r <= '0;
    end else if (state_r != S_WAIT) begin
      wdog_cnt_r <= '0;
    end else if (!mul_done) begin
      wdog_cnt_r <= wdog_inc_s;
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // Error flag rides along with the timed-out response and drops when RESP is left.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsp_err <= 1'b0;
    end else if (state_nxt_s == S_RESP) begin
      rsp_err <= rsp_err | timeout_s;
    end else begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fmadd_seq_ctrl.sv
// Directed bench for fmadd_seq_ctrl with a timeline-based reference model checked every cycle.
// Define FMADD_SEQ_CTRL_WDOG_EN for both bench and RTL to exercise the watchdog.
module tb_fmadd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_a, req_b, req_c;
  logic        flush;
  logic [31:0] op_a, op_b, op_c;
  logic [2:0]  op_rm;
  logic        op_neg_prod, op_neg_add;
  logic        mul_start, mul_done;
  logic        pn_en, add_en, rnd_en;
  logic        rsp_valid, rsp_ready, rsp_err, busy;

`ifdef FMADD_SEQ_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int WDOG_CYC = 15;

  fmadd_seq_ctrl #(.STD(31), .OPW(2), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .flush(flush), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_rm(op_rm),
    .op_neg_prod(op_neg_prod), .op_neg_add(op_neg_add), .mul_start(mul_start),
    .mul_done(mul_done), .pn_en(pn_en), .add_en(add_en), .rnd_en(rnd_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: an op is a timeline counted in edges since accept (m_t),
  // with the edge where mul_done was seen (m_dt) anchoring the three stage strobes.
  bit          m_act, m_resp, m_err;
  int          m_t, m_dt;
  logic [31:0] m_a, m_b, m_c;
  logic [2:0]  m_rm;
  logic        m_np, m_na;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_act = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_t = 0; m_dt = -1;
      m_a = '0; m_b = '0; m_c = '0; m_rm = '0; m_np = 1'b0; m_na = 1'b0;
    end else if (m_act && flush) begin
      m_act = 1'b0; m_resp = 1'b0; m_err = 1'b0;
    end else if (m_act) begin
      if (m_resp) begin
        if (rsp_ready) begin
          m_act = 1'b0; m_resp = 1'b0; m_err = 1'b0;
        end
      end else begin
        if (m_t >= 2 && m_dt < 0) begin
          if (mul_done) m_dt = m_t;
          else if (WDOG && (m_t - 1) == WDOG_CYC) begin
            m_resp = 1'b1; m_err = 1'b1;
          end
        end
        m_t++;
        if (m_dt >= 0 && m_t == m_dt + 4) m_resp = 1'b1;
      end
    end else if (req_valid && !flush) begin
      m_act = 1'b1; m_resp = 1'b0; m_err = 1'b0; m_t = 1; m_dt = -1;
      m_a = req_a; m_b = req_b; m_c = req_c; m_rm = req_rm;
      m_np = req_op[1]; m_na = req_op[0] ^ req_op[1];
    end
  end

  logic [7:0] exp_ctrl;
  always @(negedge clk) begin
    if (rst_l) begin
      exp_ctrl = {!m_act, m_act,
                  m_act && !m_resp && m_t == 1,
                  m_act && !m_resp && m_dt >= 0 && m_t == m_dt + 1,
                  m_act && !m_resp && m_dt >= 0 && m_t == m_dt + 2,
                  m_act && !m_resp && m_dt >= 0 && m_t == m_dt + 3,
                  m_act && m_resp, m_act && m_resp && m_err};
      check("ctrl", {120'd0, req_ready, busy, mul_start, pn_en, add_en, rnd_en, rsp_valid, rsp_err},
            {120'd0, exp_ctrl});
      check("ops", {27'd0, op_a, op_b, op_c, op_rm, op_neg_prod, op_neg_add},
            {27'd0, m_a, m_b, m_c, m_rm, m_np, m_na});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] rm);
    req_op = op; req_a = a; req_b = b; req_c = c; req_rm = rm;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse_done;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  task automatic wait_rsp;
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    check("rsp_arrives", {127'd0, rsp_valid}, 128'd1);
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // From START: into WAIT, mul_done in first WAIT cycle, run to response and complete it.
  task automatic do_rest;
    tick();
    pulse_done();
    wait_rsp();
    finish_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sops [3];
    logic       snp  [3];
    logic       sna  [3];
    int         n;
    sops = '{2'b10, 2'b11, 2'b01};
    snp  = '{1'b1, 1'b1, 1'b0};
    sna  = '{1'b1, 1'b0, 1'b1};

    rst_l = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_rm = 3'd0;
    req_a = 32'd0; req_b = 32'd0; req_c = 32'd0;
    flush = 1'b0; mul_done = 1'b0; rsp_ready = 1'b0;
    #22;
    check("rst_req_ready", {127'd0, req_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_op_a", {96'd0, op_a}, 128'd0);
    rst_l = 1'b1;
    tick();

    // Basic FMADD, minimum latency
    accept(2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b000);
    check("basic_start", {127'd0, mul_start}, 128'd1);
    tick();
    check("basic_start_single", {127'd0, mul_start}, 128'd0);
    pulse_done();
    check("basic_pn", {126'd0, pn_en, add_en}, 128'd2);
    tick();
    check("basic_add", {126'd0, add_en, rnd_en}, 128'd2);
    tick();
    check("basic_rnd", {126'd0, rnd_en, rsp_valid}, 128'd2);
    tick();
    check("basic_rsp_lat5", {127'd0, rsp_valid}, 128'd1);
    check("basic_signs", {126'd0, op_neg_prod, op_neg_add}, 128'd0);
    check("basic_op_b", {96'd0, op_b}, 128'h40000000);
    finish_rsp();
    check("basic_idle", {127'd0, busy}, 128'd0);

    // Sign decode
    for (int i = 0; i < 3; i++) begin
      accept(sops[i], 32'h40400000 + i, 32'hBF800000, 32'h41200000, 3'(i + 1));
      check("sign_decode", {126'd0, op_neg_prod, op_neg_add}, {126'd0, snp[i], sna[i]});
      do_rest();
    end

    // Backpressure with a new request waiting
    accept(2'b00, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001);
    tick();
    pulse_done();
    wait_rsp();
    req_valid = 1'b1; req_a = 32'hAAAA5555; req_op = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold", {96'd0, rsp_valid, req_ready, op_a[29:0]}, {96'd0, 1'b1, 1'b0, 30'h11111111});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_after_hs", {126'd0, req_ready, busy}, 128'd2);
    tick();
    req_valid = 1'b0;
    check("bp_new_accept", {96'd0, op_a}, 128'hAAAA5555);
    do_rest();

    // Flush in WAIT, with mul_done arriving at the same edge
    accept(2'b01, 32'h1, 32'h2, 32'h3, 3'b010);
    tick();
    flush = 1'b1; mul_done = 1'b1;
    tick();
    flush = 1'b0; mul_done = 1'b0;
    check("flush_wait", {125'd0, busy, pn_en, rsp_valid}, 128'd0);
    tick();
    accept(2'b00, 32'h5, 32'h6, 32'h7, 3'b000);
    do_rest();

    // Flush in RESP with rsp_ready high drops the response
    accept(2'b10, 32'h8, 32'h9, 32'hA, 3'b011);
    tick();
    pulse_done();
    wait_rsp();
    flush = 1'b1; rsp_ready = 1'b1;
    tick();
    flush = 1'b0; rsp_ready = 1'b0;
    check("flush_resp", {126'd0, busy, rsp_valid}, 128'd0);
    accept(2'b00, 32'hB, 32'hC, 32'hD, 3'b100);
    do_rest();

    // Flush in IDLE blocks acceptance
    req_op = 2'b11; req_a = 32'hCAFEF00D; req_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_block", {127'd0, busy}, 128'd0);
    tick();
    req_valid = 1'b0;
    check("flush_idle_then_accept", {95'd0, busy, op_a}, {95'd0, 1'b1, 32'hCAFEF00D});
    do_rest();

    // Async reset mid-ADD
    accept(2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 3'b001);
    tick();
    pulse_done();
    tick();
    check("pre_reset_add", {127'd0, add_en}, 128'd1);
    #2;
    rst_l = 1'b0;
    #1;
    check("async_rst", {93'd0, add_en, busy, req_ready, op_a}, {93'd0, 1'b0, 1'b0, 1'b1, 32'd0});
    @(negedge clk);
    #2;
    rst_l = 1'b1;
    tick();
    accept(2'b01, 32'h3, 32'h4, 32'h5, 3'b000);
    do_rest();

    // Multiplier never answers
    accept(2'b00, 32'h77, 32'h88, 32'h99, 3'b000);
    tick();
    if (WDOG) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        tick();
        n++;
      end
      check("wdog_latency", 128'(n), 128'd15);
      check("wdog_err", {127'd0, rsp_err}, 128'd1);
      finish_rsp();
      check("wdog_err_clear", {126'd0, rsp_err, busy}, 128'd0);
    end else begin
      for (int i = 0; i < 100; i++) begin
        tick();
        check("no_wdog_wait", {125'd0, busy, rsp_valid, rsp_err}, 128'd4);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("no_wdog_flush", {127'd0, busy}, 128'd0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmadd_seq_ctrl.md
Name: fmadd_seq_ctrl

Overview:
- Sequencing controller for the single-precision fused multiply-add datapath.
- Accepts one FMADD/FMSUB/FNMSUB/FNMADD request at a time over a valid/ready handshake and latches the operands, rounding mode and sign controls.
- Steps the datapath through its stages in order: multiply start, wait for multiply done, multiply post-normalization, align/add, round.
- Returns a completion over a second valid/ready handshake. Sits between the FPU issue logic and the FMADD stage registers.

Parameters:
- STD, 31, operand width minus 1.
- OPW, 2, request opcode width.
- WDOG_CYC, 15, watchdog limit in cycles (used only when the watchdog is compiled in).

Ports:
- clk  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept
- req_op  input  OPW  00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
- req_rm  input  3  rounding mode
- req_a, req_b, req_c  input  STD+1 each  operands, computing a*b±c
- flush  input  1  synchronous abort of the in-flight op
- op_a, op_b, op_c  output  STD+1 each  latched operands driven to the datapath
- op_rm  output  3  latched rounding mode
- op_neg_prod  output  1  negate product (req_op[1])
- op_neg_add  output  1  negate addend (req_op[0] XOR req_op[1])
- mul_start  output  1  one-cycle multiplier launch pulse
- mul_done  input  1  multiplier result valid (variable latency, ≥1 cycle after mul_start)
- pn_en, add_en, rnd_en  output  1 each  one-cycle stage capture enables
- rsp_valid  output  1  result ready in the datapath output register
- rsp_ready  input  1  consumer accepts
- rsp_err  output  1  op aborted by watchdog; valid with rsp_valid
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_l=0): state=IDLE. All outputs 0 except req_ready=1. op_* registers cleared to 0, watchdog counter cleared.
- States: IDLE, START, WAIT, PN, ADD, RND, RESP. Encoding is free.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch req_a/b/c, req_rm and the derived sign bits into op_*; go to START.
- START: mul_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - On mul_done=1, go to PN.
  - mul_done is ignored in START.
  - mul_done seen in IDLE, PN, ADD, RND or RESP is ignored.
- PN, ADD, RND: assert pn_en, add_en, rnd_en respectively for one cycle each, in that order. Transitions are unconditional.
- RESP:
  - rsp_valid=1 and held stable until rsp_ready=1; go to IDLE on that edge.
  - rsp_valid is not asserted in any other state.
- Minimum latency: request accept edge to rsp_valid high is 5 cycles when mul_done rises in the first WAIT cycle.
- req_ready=0 in every state except IDLE. No back-to-back overlap: the next request is accepted at the earliest on the cycle after the RESP handshake.
- op_* registers hold their value from accept until the next accept. They change only on accept.
- flush:
  - In any non-IDLE state, flush=1 forces IDLE on the next edge, with no response and no stage enables that cycle.
  - Flush has priority over every other transition, including the RESP handshake (that response is dropped).
  - In IDLE, flush blocks acceptance that cycle.
- Reset mid-operation: immediate return to IDLE values; the pending response is lost.

Optional Feature:
- Macro FMADD_SEQ_CTRL_WDOG_EN.
- Enabled:
  - A counter of ceil(log2(WDOG_CYC+1)) bits clears on entering WAIT and increments each WAIT cycle without mul_done.
  - When it reaches WAIT_CYC-equivalent WDOG_CYC, go directly to RESP with rsp_err=1. PN/ADD/RND enables are skipped.
  - rsp_err clears on the RESP handshake.
- Disabled: no counter logic; WAIT waits indefinitely; rsp_err tied to 0.

Test Plan:
- Basic op: req_op=00, a=0x3F800000, b=0x40000000, c=0x3F000000, rm=000; mul_done 1 cycle after mul_start -> mul_start single pulse; pn_en, add_en, rnd_en on consecutive cycles; rsp_valid 5 cycles after accept; op_neg_prod=0, op_neg_add=0.
- Sign decode: req_op=10 -> op_neg_prod=1, op_neg_add=1; req_op=11 -> op_neg_prod=1, op_neg_add=0; req_op=01 -> 0,1.
- Backpressure: rsp_ready held 0 for 4 cycles while req_valid=1 with new operands -> rsp_valid steady, req_ready=0, op_a unchanged; new op accepted the cycle after the handshake.
- Flush during WAIT, and a second case flushing in RESP with rsp_ready=1 -> IDLE next edge, no rsp_valid pulse, no pn_en; the following request completes normally.
- Async reset: drop rst_l mid-ADD, off clock edge -> outputs 0 and req_ready=1 immediately, before the next edge.
- With FMADD_SEQ_CTRL_WDOG_EN and WDOG_CYC=15: mul_done never asserted -> rsp_valid with rsp_err=1 exactly 15 cycles after entering WAIT. Without the macro, the same stimulus stays in WAIT and busy=1 for 100 cycles.
